// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO result registers and fixed-latency sequencing.
// Optional macro MD_UNIT_ACCUM_EN enables MADD/MADDU/MSUB/MSUBU (ops 4-7).
module md_unit #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  input  logic [1:0]       Wsel,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             DivZero
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] MULT_CNT = CW'(MULT_LAT);
  localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_LAT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             divzero_q, divzero_d;

  // Opcode decode for the incoming request
  logic start_legal;
  logic start_is_div;
`ifdef MD_UNIT_ACCUM_EN
  assign start_legal = 1'b1;
`else
  assign start_legal = ~Op[2];
`endif
  assign start_is_div = (Op[2:1] == 2'b01);

  // Datapath on latched operands; op bit 0 selects the unsigned variant
  logic             is_signed;
  logic             run_is_div;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod, mul_res;

  assign is_signed  = ~op_q[0];
  assign run_is_div = (op_q[2:1] == 2'b01);
  assign a_ext = {{WIDTH{a_q[WIDTH-1] & is_signed}}, a_q};
  assign b_ext = {{WIDTH{b_q[WIDTH-1] & is_signed}}, b_q};
  assign prod  = a_ext * b_ext;

`ifdef MD_UNIT_ACCUM_EN
  logic [2*WIDTH-1:0] hilo;
  logic [2*WIDTH-1:0] acc_res;
  assign hilo    = {hi_q, lo_q};
  assign acc_res = op_q[1] ? (hilo - prod) : (hilo + prod);
  assign mul_res = op_q[2] ? acc_res : prod;
`else
  assign mul_res = prod;
`endif

  // Sign-magnitude divide: one unsigned divider serves both DIV and DIVU.
  // Most-negative / -1 falls out naturally as quotient = most-negative, rem = 0.
  logic             a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag, b_safe;
  logic [WIDTH-1:0] q_mag, r_mag, quo, rem;

  assign a_neg  = is_signed & a_q[WIDTH-1];
  assign b_neg  = is_signed & b_q[WIDTH-1];
  assign a_mag  = a_neg ? (~a_q + 1'b1) : a_q;
  assign b_mag  = b_neg ? (~b_q + 1'b1) : b_q;
  assign b_zero = (b_q == '0);
  assign b_safe = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
  assign q_mag  = a_mag / b_safe;
  assign r_mag  = a_mag % b_safe;
  assign quo    = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
  assign rem    = a_neg ? (~r_mag + 1'b1) : r_mag;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    divzero_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          if (start_legal) begin
            a_d     = D1;
            b_d     = D2;
            op_d    = Op;
            cnt_d   = start_is_div ? DIV_CNT : MULT_CNT;
            state_d = RUN;
          end
        end else begin
          if (Wsel == 2'd1) hi_d = D1;
          if (Wsel == 2'd2) lo_d = D1;
        end
      end
      RUN: begin
        if (cnt_q == CNT_ONE) begin
          state_d = IDLE;
          if (run_is_div) begin
            if (b_zero) begin
              divzero_d = 1'b1;
            end else begin
              hi_d = rem;
              lo_d = quo;
            end
          end else begin
            hi_d = mul_res[2*WIDTH-1:WIDTH];
            lo_d = mul_res[WIDTH-1:0];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      divzero_q <= divzero_d;
    end
  end

  assign Hi      = hi_q;
  assign Lo      = lo_q;
  assign Busy    = (state_q == RUN);
  assign DivZero = divzero_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus pushes expected commits, a monitor checks them.
module tb_md_unit;

  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         Reset, Start;
  logic [2:0]   Op;
  logic [W-1:0] D1, D2;
  logic [1:0]   Wsel;
  logic [W-1:0] Hi, Lo;
  logic         Busy, DivZero;

  md_unit #(.WIDTH(W), .MULT_LAT(5), .DIV_LAT(10)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .D1(D1), .D2(D2),
    .Wsel(Wsel), .Hi(Hi), .Lo(Lo), .Busy(Busy), .DivZero(DivZero)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string      name;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic       dz;
    int         lat;   // -1: aborted, latency not checked
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  function automatic void check(string name, logic [W-1:0] got, logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, want);
    end else begin
      $display("ok   %s value=%h", name, got);
    end
  endfunction

  // Monitor: one transaction closes when Busy falls
  logic busy_prev = 1'b0;
  int   busy_cnt  = 0;
  always @(negedge Clk) begin
    if (Busy) busy_cnt++;
    if (busy_prev && !Busy) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_commit got=Hi:%h Lo:%h exp=none", Hi, Lo);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, "_hi"}, Hi, e.hi);
        check({e.name, "_lo"}, Lo, e.lo);
        check({e.name, "_dz"}, W'(DivZero), W'(e.dz));
        if (e.lat > 0) check({e.name, "_lat"}, W'(busy_cnt), W'(e.lat));
      end
      busy_cnt = 0;
    end else if (DivZero) begin
      checks++;
      failures++;
      $display("FAIL divzero_stray got=1 exp=0 at %0t", $time);
    end
    busy_prev = Busy;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(string name, logic [W-1:0] hi, logic [W-1:0] lo, logic dz, int lat);
    exp_t e;
    e.name = name; e.hi = hi; e.lo = lo; e.dz = dz; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    while (Busy && n < 40) begin
      tick();
      n++;
    end
    if (Busy) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout got=busy exp=idle", name);
    end
    tick();
  endtask

  task automatic run_op(string name, logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b,
                        logic [W-1:0] hi, logic [W-1:0] lo, logic dz, int lat);
    push(name, hi, lo, dz, lat);
    Start = 1'b1; Op = op; D1 = a; D2 = b;
    tick();
    Start = 1'b0;
    wait_idle(name);
  endtask

  task automatic wr(logic [1:0] sel, logic [W-1:0] d);
    Wsel = sel; D1 = d;
    tick();
    Wsel = 2'd0;
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Op = 3'd0; D1 = '0; D2 = '0; Wsel = 2'd0;
    repeat (3) tick();
    check("reset_hi", Hi, '0);
    check("reset_lo", Lo, '0);
    check("reset_busy", W'(Busy), '0);
    check("reset_dz", W'(DivZero), '0);
    Reset = 1'b0;

    run_op("mult",  3'd0, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 5);
    run_op("multu", 3'd1, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, 1'b0, 5);
    run_op("div",   3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 10);
    run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 10);
    run_op("divu",  3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 10);
    run_op("div_mix", 3'd2, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0, 10);

    wr(2'd1, 32'd5);
    wr(2'd2, 32'd7);
    check("wsel_hi", Hi, 32'd5);
    check("wsel_lo", Lo, 32'd7);
    wr(2'd3, 32'd99);
    check("wsel3_hi", Hi, 32'd5);
    check("wsel3_lo", Lo, 32'd7);
    run_op("divu_zero", 3'd3, 32'd9, 32'd0, 32'd5, 32'd7, 1'b1, 10);

    wr(2'd1, 32'd0);
    wr(2'd2, 32'd10);
`ifdef MD_UNIT_ACCUM_EN
    run_op("madd", 3'd4, 32'd3, 32'd4, 32'd0, 32'd22, 1'b0, 5);
    run_op("msub", 3'd6, 32'd5, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 5);
`else
    Start = 1'b1; Op = 3'd4; D1 = 32'd3; D2 = 32'd4; Wsel = 2'd1;
    tick();
    Start = 1'b0; Wsel = 2'd0;
    check("madd_off_busy", W'(Busy), '0);
    tick();
    check("madd_off_busy2", W'(Busy), '0);
    check("madd_off_lo", Lo, 32'd10);
    check("madd_off_hi", Hi, 32'd0);
`endif

    // Start and Wsel during Busy must not disturb the running MULT
    push("busy_ign", 32'd0, 32'd42, 1'b0, 5);
    Start = 1'b1; Op = 3'd0; D1 = 32'd6; D2 = 32'd7;
    tick();
    Op = 3'd2; D1 = 32'h1234; D2 = 32'd1; Wsel = 2'd1;
    tick();
    tick();
    Start = 1'b0; Wsel = 2'd0;
    wait_idle("busy_ign");

    // Reset mid-operation aborts without commit
    wr(2'd1, 32'h55);
    wr(2'd2, 32'h66);
    push("abort", 32'd0, 32'd0, 1'b0, -1);
    Start = 1'b1; Op = 3'd3; D1 = 32'd100; D2 = 32'd7;
    tick();
    Start = 1'b0;
    repeat (3) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("abort_busy", W'(Busy), '0);
    check("abort_hi", Hi, '0);
    check("abort_lo", Lo, '0);
    run_op("post_reset", 3'd1, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 5);

    repeat (3) tick();
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL pending_expect got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
